// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: shared definitions for the multi-cycle ALU.
//   - opcode encodings for ops 0..10 (11..15 are reserved)
//   - FSM state encoding for alu_mc
//   - iterative datapath mode encoding
//   - cnt_width(): iteration counter width for a given operand width
// Optional feature macro: ALU_MC_DIV_EN (enables the divider; see alu_mc.sv).
package alu_mc_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_PAS1  = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_PAS2  = 4'd3;
  localparam logic [3:0] OP_MULLO = 4'd4;
  localparam logic [3:0] OP_MULHI = 4'd5;
  localparam logic [3:0] OP_DIVQ  = 4'd6;
  localparam logic [3:0] OP_DIVR  = 4'd7;
  localparam logic [3:0] OP_AND   = 4'd8;
  localparam logic [3:0] OP_OR    = 4'd9;
  localparam logic [3:0] OP_XOR   = 4'd10;

  // ST_DIVZ is a reserved encoding: divide-by-zero finishes at the accept
  // edge from IDLE, so the FSM never needs to enter it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DIVZ = 2'd2
  } state_t;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  // Counter must hold the value WIDTH itself, hence WIDTH+1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// alu_mc_iter: shared iterative shift datapath for multiply and divide.
//   clock, reset_n : clock, synchronous active-low reset
//   start          : load operands and begin WIDTH iterations
//   mode           : MODE_MUL (shift-add) or MODE_DIV (restoring divide)
//   a, b           : multiplier/dividend, multiplicand/divisor
//   done           : high during the cycle whose edge performs the last iteration
//   acc_nxt        : accumulator value produced by the current iteration
//                    (product, or {remainder, quotient} in divide mode)
// The divider half is only built when ALU_MC_DIV_EN is defined.
module alu_mc_iter
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   acc_nxt
);

  localparam int CW = cnt_width(WIDTH);

  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     b_q;

  // Multiply: low half starts as the multiplier and is shifted out LSB first
  // while partial sums enter from the top.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_nxt;

  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
    if (acc[0]) mul_nxt = {mul_sum, acc[WIDTH-1:1]};
    else        mul_nxt = {1'b0, acc[2*WIDTH-1:1]};
  end

`ifdef ALU_MC_DIV_EN
  logic                 mode_q;
  logic [WIDTH:0]       div_rs;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   div_nxt;

  // Restoring divide: shift {rem, quot} left, trial-subtract the divisor
  // from the widened remainder; a clear borrow bit means the subtract sticks.
  always_comb begin
    div_rs   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff = div_rs - {1'b0, b_q};
    if (!div_diff[WIDTH]) div_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else                  div_nxt = {div_rs[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clock) begin
    if (!reset_n)   mode_q <= MODE_MUL;
    else if (start) mode_q <= mode;
  end

  assign acc_nxt = (mode_q == MODE_DIV) ? div_nxt : mul_nxt;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign acc_nxt     = mul_nxt;
`endif

  // cnt == 0 means idle; loaded with WIDTH, the last iteration happens on
  // the edge where it steps from 1 to 0.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt <= '0;
      acc <= '0;
      b_q <= '0;
    end else if (start) begin
      cnt <= CW'(WIDTH);
      acc <= {{WIDTH{1'b0}}, a};
      b_q <= b;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      acc <= acc_nxt;
    end
  end

  assign done = (cnt == CW'(1));

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU (add/sub/pass/logic in one cycle, multiply and
// divide over WIDTH cycles on a shared iterative datapath).
//   clock, reset_n      : clock, synchronous active-low reset
//   in_valid, in_ready  : request handshake (in_ready high iff FSM is IDLE)
//   op, var1, var2      : opcode and operands, captured on accept
//   out_valid           : one-cycle pulse marking a new result/flags
//   result, carry, zero, err : registered outputs, held between completions
// Macro ALU_MC_DIV_EN: when defined, ops 6/7 divide; otherwise they are
// treated as reserved opcodes.
//
// Handshake: a request is accepted on a rising edge where in_valid and
// in_ready are both high. Nothing is queued; in_valid while in_ready is low
// has no effect. out_valid is a single-cycle pulse with no backpressure.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   var1,
  input  logic [WIDTH-1:0]   var2,
  output logic               out_valid,
  output logic [WIDTH-1:0]   result,
  output logic               carry,
  output logic               zero,
  output logic               err
);

  state_t state;
  logic   sel_hi;      // completing op reads the upper accumulator half

  logic accept;
  logic op_is_mul;
  logic op_is_div;
  logic start_iter;

  logic [WIDTH:0] s_res;
  logic           s_carry;
  logic           s_err;

  logic               iter_done;
  logic [2*WIDTH-1:0] iter_acc;
  logic [WIDTH-1:0]   iter_res;

  assign in_ready  = (state == ST_IDLE);
  assign accept    = in_valid & in_ready;
  assign op_is_mul = (op == OP_MULLO) || (op == OP_MULHI);
  assign op_is_div = (op == OP_DIVQ) || (op == OP_DIVR);

`ifdef ALU_MC_DIV_EN
  assign start_iter = accept & (op_is_mul | (op_is_div & (var2 != '0)));
`else
  assign start_iter = accept & op_is_mul;
`endif

  // Single-cycle ops, plus the immediate completions (reserved op and
  // divide-by-zero). Iterative ops never use this value.
  always_comb begin
    s_res   = '0;
    s_carry = 1'b0;
    s_err   = 1'b0;
    case (op)
      OP_ADD: begin
        s_res   = {1'b0, var1} + {1'b0, var2};
        s_carry = s_res[WIDTH];
      end
      OP_SUB: begin
        // Bit WIDTH of the widened difference is the unsigned borrow.
        s_res   = {1'b0, var1} - {1'b0, var2};
        s_carry = s_res[WIDTH];
      end
      OP_PAS1:  s_res = {1'b0, var1};
      OP_PAS2:  s_res = {1'b0, var2};
      OP_AND:   s_res = {1'b0, var1 & var2};
      OP_OR:    s_res = {1'b0, var1 | var2};
      OP_XOR:   s_res = {1'b0, var1 ^ var2};
      OP_MULLO, OP_MULHI: s_res = '0;
`ifdef ALU_MC_DIV_EN
      OP_DIVQ: begin
        s_res = {1'b0, {WIDTH{1'b1}}};
        s_err = 1'b1;
      end
      OP_DIVR: begin
        s_res = {1'b0, var1};
        s_err = 1'b1;
      end
`endif
      default: s_err = 1'b1;
    endcase
  end

  alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start_iter),
    .mode    (op_is_div ? MODE_DIV : MODE_MUL),
    .a       (var1),
    .b       (var2),
    .done    (iter_done),
    .acc_nxt (iter_acc)
  );

  assign iter_res = sel_hi ? iter_acc[2*WIDTH-1:WIDTH] : iter_acc[WIDTH-1:0];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      sel_hi    <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_iter) begin
            state  <= ST_ITER;
            sel_hi <= (op == OP_MULHI) || (op == OP_DIVR);
          end else if (accept) begin
            out_valid <= 1'b1;
            result    <= s_res[WIDTH-1:0];
            carry     <= s_carry;
            zero      <= (s_res[WIDTH-1:0] == '0);
            err       <= s_err;
          end
        end
        ST_ITER: begin
          if (iter_done) begin
            state     <= ST_IDLE;
            out_valid <= 1'b1;
            result    <= iter_res;
            carry     <= 1'b0;
            zero      <= (iter_res == '0);
            err       <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc at WIDTH=16.
module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] var1;
  logic [W-1:0] var2;
  logic         out_valid;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;
  logic         err;

  int n_cmp  = 0;
  int n_fail = 0;
  int edges;
  int low;

  alu_mc #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .var1      (var1),
    .var2      (var2),
    .out_valid (out_valid),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .err       (err)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op, then wait (bounded) for out_valid. edges counts clock
  // edges after the accept edge; low counts sampled cycles with in_ready low.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int e, output int l);
    op = o; var1 = a; var2 = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    e = 0; l = 0;
    while (!out_valid && e < 100) begin
      if (!in_ready) l++;
      tick();
      e++;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_n = 1'b0; in_valid = 1'b0; op = '0; var1 = '0; var2 = '0;
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_result",    32'(result),    32'h0);
    check("rst_carry",     32'(carry),     32'h0);
    check("rst_zero",      32'(zero),      32'h0);
    check("rst_err",       32'(err),       32'h0);
    reset_n = 1'b1;
    tick();
    check("rst_in_ready",  32'(in_ready),  32'h1);

    // ADD with carry-out and zero result
    run_op(OP_ADD, 16'hFFFF, 16'h0001, edges, low);
    check("add_lat",    32'(edges),     32'd0);
    check("add_valid",  32'(out_valid), 32'h1);
    check("add_result", 32'(result),    32'h0000);
    check("add_carry",  32'(carry),     32'h1);
    check("add_zero",   32'(zero),      32'h1);
    check("add_err",    32'(err),       32'h0);
    tick();
    check("add_pulse",  32'(out_valid), 32'h0);

    // SUB with borrow
    run_op(OP_SUB, 16'h0003, 16'h0005, edges, low);
    check("sub_result", 32'(result), 32'hFFFE);
    check("sub_borrow", 32'(carry),  32'h1);
    check("sub_zero",   32'(zero),   32'h0);

    // MULHI: 0xFFFF * 0xFFFF = 0xFFFE0001
    run_op(OP_MULHI, 16'hFFFF, 16'hFFFF, edges, low);
    check("mulhi_lat",    32'(edges),    32'd16);
    check("mulhi_busy",   32'(low),      32'd16);
    check("mulhi_result", 32'(result),   32'hFFFE);
    check("mulhi_carry",  32'(carry),    32'h0);
    check("mulhi_ready",  32'(in_ready), 32'h1);

    run_op(OP_MULLO, 16'hFFFF, 16'hFFFF, edges, low);
    check("mullo_lat",    32'(edges),  32'd16);
    check("mullo_result", 32'(result), 32'h0001);
    check("mullo_zero",   32'(zero),   32'h0);
    check("mullo_err",    32'(err),    32'h0);

`ifdef ALU_MC_DIV_EN
    run_op(OP_DIVQ, 16'd100, 16'd7, edges, low);
    check("divq_lat",    32'(edges),  32'd16);
    check("divq_result", 32'(result), 32'd14);
    check("divq_err",    32'(err),    32'h0);
    run_op(OP_DIVR, 16'd100, 16'd7, edges, low);
    check("divr_lat",    32'(edges),  32'd16);
    check("divr_result", 32'(result), 32'd2);
    run_op(OP_DIVQ, 16'd5, 16'd0, edges, low);
    check("divq0_lat",    32'(edges),  32'd0);
    check("divq0_result", 32'(result), 32'hFFFF);
    check("divq0_err",    32'(err),    32'h1);
    run_op(OP_DIVR, 16'd5, 16'd0, edges, low);
    check("divr0_lat",    32'(edges),  32'd0);
    check("divr0_result", 32'(result), 32'h0005);
    check("divr0_err",    32'(err),    32'h1);
`else
    // Divider not built: ops 6/7 behave as reserved opcodes.
    run_op(OP_DIVQ, 16'd100, 16'd7, edges, low);
    check("divq_nodiv_lat",    32'(edges),  32'd0);
    check("divq_nodiv_result", 32'(result), 32'h0);
    check("divq_nodiv_err",    32'(err),    32'h1);
    check("divq_nodiv_zero",   32'(zero),   32'h1);
    run_op(OP_DIVR, 16'd5, 16'd0, edges, low);
    check("divr_nodiv_lat",    32'(edges),  32'd0);
    check("divr_nodiv_result", 32'(result), 32'h0);
    check("divr_nodiv_err",    32'(err),    32'h1);
`endif

    // Back-to-back logic ops, one per cycle
    var1 = 16'hF0F0; var2 = 16'h0FF0; in_valid = 1'b1;
    op = OP_AND; tick();
    check("and_valid",  32'(out_valid), 32'h1);
    check("and_result", 32'(result),    32'h00F0);
    op = OP_OR; tick();
    check("or_valid",   32'(out_valid), 32'h1);
    check("or_result",  32'(result),    32'hFFF0);
    op = OP_XOR; tick();
    check("xor_valid",  32'(out_valid), 32'h1);
    check("xor_result", 32'(result),    32'hFF00);
    in_valid = 1'b0; tick();
    check("b2b_idle",   32'(out_valid), 32'h0);

    // Reserved opcode
    run_op(4'd12, 16'h1234, 16'h5678, edges, low);
    check("rsvd_lat",    32'(edges),  32'd0);
    check("rsvd_result", 32'(result), 32'h0);
    check("rsvd_err",    32'(err),    32'h1);
    check("rsvd_zero",   32'(zero),   32'h1);

    // MULLO with an ADD held on in_valid during ITER: the ADD must wait.
    op = OP_MULLO; var1 = 16'd300; var2 = 16'd300; in_valid = 1'b1;
    tick();
    op = OP_ADD; var1 = 16'd1; var2 = 16'd1;
    edges = 0;
    while (!out_valid && edges < 100) begin
      tick();
      edges++;
    end
    check("hold_mul_lat",    32'(edges),    32'd16);
    check("hold_mul_result", 32'(result),   32'h5F90);
    check("hold_mul_ready",  32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    check("hold_add_valid",  32'(out_valid), 32'h1);
    check("hold_add_result", 32'(result),    32'h0002);

    // Reset asserted at iteration 8 of a MULHI
    op = OP_MULHI; var1 = 16'hFFFF; var2 = 16'hFFFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    reset_n = 1'b0;
    tick();
    check("midrst_valid",  32'(out_valid), 32'h0);
    check("midrst_result", 32'(result),    32'h0);
    check("midrst_carry",  32'(carry),     32'h0);
    check("midrst_zero",   32'(zero),      32'h0);
    check("midrst_err",    32'(err),       32'h0);
    reset_n = 1'b1;
    low = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) low++;
    end
    check("midrst_no_valid", 32'(low),      32'd0);
    check("midrst_ready",    32'(in_ready), 32'h1);

    // Normal operation after the aborted op
    run_op(OP_ADD, 16'h1234, 16'h0001, edges, low);
    check("post_add_result", 32'(result), 32'h1235);
    check("post_add_carry",  32'(carry),  32'h0);
    run_op(OP_PAS2, 16'h1111, 16'hABCD, edges, low);
    check("pas2_result", 32'(result), 32'hABCD);
    run_op(OP_PAS1, 16'h1111, 16'hABCD, edges, low);
    check("pas1_result", 32'(result), 32'h1111);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "time limit");
  end

endmodule
